// File: rtl/mips_mem_responder.sv
// Unified instruction/data memory responder for the multicycle MIPS core.
// One request in flight at a time; the response pulse follows a configurable number of wait states.
module mips_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    output logic          busy
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // the core holds req_valid and the request fields stable until that edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        enter_resp;
    logic        accept;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_err;
    logic [AW-1:0] c_idx;

    logic [31:0] mem [DEPTH_WORDS];

    assign req_ready = (state == S_IDLE) && !ld_en && !reset;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != S_IDLE);

    // With zero wait states the commit edge is the accept edge, so use the live request fields.
    assign c_we    = (state == S_IDLE) ? req_we    : lat_we;
    assign c_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
    assign c_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;
    assign c_err   = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= 30'(DEPTH_WORDS));
    assign c_idx   = c_addr[AW+1:2];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // resp_valid trails the RESP state by one edge, so the pulse lands in the first IDLE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            resp_valid <= (state == S_RESP);
            if (enter_resp) begin
                resp_err   <= c_err;
                resp_rdata <= (c_err || c_we) ? 32'd0 : mem[c_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // Loader writes only land in IDLE, where no commit can coincide with them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (enter_resp && c_we && !c_err) begin
                mem[c_idx] <= c_wdata;
            end else if (ld_en && (state == S_IDLE)) begin
                mem[ld_addr] <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: two instances (2 and 0 wait states) checked against a
// transaction-level memory model with an expected-response queue.
module tb_mips_mem_responder;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        ld_en      [2];
    logic [5:0]  ld_addr    [2];
    logic [31:0] ld_data    [2];
    logic        busy       [2];

    logic [31:0] mm [2][64];
    req_t        req_q[$];
    logic [32:0] exp_q[$];
    int          acc_q[$];
    int          n_checks;
    int          n_fail;

    mips_mem_responder #(.DEPTH_WORDS(64), .AW(6), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .busy(busy[0])
    );

    mips_mem_responder #(.DEPTH_WORDS(64), .AW(6), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .busy(busy[1])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wc(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: whole-word memory, errors for misaligned or beyond-the-array addresses
    task automatic model(input int i, input req_t r, output logic [32:0] e);
        int unsigned word;
        word = r.addr / 4;
        if ((r.addr % 4) != 0 || word >= 64) begin
            e = {1'b1, 32'd0};
        end else if (r.we) begin
            mm[i][word] = r.wdata;
            e = {1'b0, 32'd0};
        end else begin
            e = {1'b0, mm[i][word]};
        end
    endtask

    task automatic push_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.we = we;
        r.addr = addr;
        r.wdata = wdata;
        req_q.push_back(r);
    endtask

    task automatic load(input int i, input int idx, input logic [31:0] d);
        ld_en[i]   = 1'b1;
        ld_addr[i] = 6'(idx);
        ld_data[i] = d;
        @(negedge clk);
        ld_en[i] = 1'b0;
        mm[i][idx] = d;
    endtask

    // driver + scoreboard: req_valid stays high while requests are queued; called at a negedge
    task automatic run(input int i, input int budget, output int first_acc);
        int cyc;
        int last_acc;
        int a;
        logic [32:0] e;
        req_t r;
        cyc = 0;
        last_acc = -1;
        first_acc = -1;
        while ((req_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
            if (resp_valid[i]) begin
                if (exp_q.size() == 0) begin
                    check("spurious_resp", 64'(resp_valid[i]), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("resp_err", 64'(resp_err[i]), 64'(e[32]));
                    check("resp_rdata", 64'(resp_rdata[i]), 64'(e[31:0]));
                    check("latency", 64'(cyc - a), 64'(wc(i) + 2));
                end
            end
            check("busy", 64'(busy[i]), 64'(exp_q.size() != 0));
            if (req_q.size() != 0) begin
                r = req_q[0];
                req_valid[i] = 1'b1;
                req_we[i]    = r.we;
                req_addr[i]  = r.addr;
                req_wdata[i] = r.wdata;
            end else begin
                req_valid[i] = 1'b0;
            end
            #1;
            check("req_ready", 64'(req_ready[i]), 64'(exp_q.size() == 0 && !ld_en[i]));
            if (req_valid[i] && exp_q.size() == 0 && !ld_en[i]) begin
                model(i, r, e);
                exp_q.push_back(e);
                acc_q.push_back(cyc);
                if (last_acc >= 0) check("spacing", 64'(cyc - last_acc), 64'(wc(i) + 2));
                last_acc = cyc;
                if (first_acc < 0) first_acc = cyc;
                void'(req_q.pop_front());
            end
            @(negedge clk);
            cyc++;
        end
        if (req_q.size() != 0 || exp_q.size() != 0) begin
            check("timeout", 64'(1), 64'(0));
            req_q.delete();
            exp_q.delete();
            acc_q.delete();
        end
        req_valid[i] = 1'b0;
        check("pulse_width", 64'(resp_valid[i]), 64'(0));
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned sel;
        sel = $urandom_range(0, 9);
        if (sel <= 6) return {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        if (sel == 7) return {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
        if (sel == 8) return 32'($urandom_range(64, 1000)) * 4;
        return $urandom();
    endfunction

    initial begin
        int first;
        int n;
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 32'd0; req_wdata[i] = 32'd0;
            ld_en[i] = 1'b0; ld_addr[i] = 6'd0; ld_data[i] = 32'd0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_resp_valid", 64'(resp_valid[i]), 64'(0));
            check("rst_resp_rdata", 64'(resp_rdata[i]), 64'(0));
            check("rst_resp_err", 64'(resp_err[i]), 64'(0));
            check("rst_busy", 64'(busy[i]), 64'(0));
            check("rst_ready_low", 64'(req_ready[i]), 64'(0));
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) check("ready_after_rst", 64'(req_ready[i]), 64'(1));
        @(negedge clk);

        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 64; k++) load(i, k, $urandom());

        // loaded word read back with WAIT_CYCLES latency
        load(0, 3, 32'hDEADBEEF);
        push_req(1'b0, 32'h0C, 32'd0);
        run(0, 50, first);

        // store then read back, issued back to back
        push_req(1'b1, 32'h10, 32'h12345678);
        push_req(1'b0, 32'h10, 32'd0);
        run(0, 50, first);

        // misaligned, out-of-range read, out-of-range store, word 0 untouched
        push_req(1'b0, 32'h06, 32'd0);
        push_req(1'b0, 32'h100, 32'd0);
        push_req(1'b1, 32'h100, 32'hA5A5A5A5);
        push_req(1'b0, 32'h00, 32'd0);
        run(0, 80, first);

        // continuous valid, incrementing addresses
        push_req(1'b0, 32'h0, 32'd0);
        push_req(1'b0, 32'h4, 32'd0);
        push_req(1'b0, 32'h8, 32'd0);
        run(0, 80, first);

        // reset during WAIT drops the store and its response
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'hCAFEF00D;
        #1;
        check("rst_case_ready", 64'(req_ready[0]), 64'(1));
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("rst_case_busy", 64'(busy[0]), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_first_after_rst", 64'(req_ready[0]), 64'(1));
        check("rst_case_rdata", 64'(resp_rdata[0]), 64'(0));
        for (int k = 0; k < 5; k++) begin
            check("no_resp_after_rst", 64'(resp_valid[0]), 64'(0));
            @(negedge clk);
        end
        push_req(1'b0, 32'h20, 32'd0);
        run(0, 50, first);

        // loader beats a simultaneous request, which is taken right after
        for (int i = 0; i < 2; i++) begin
            ld_en[i] = 1'b1; ld_addr[i] = 6'd5; ld_data[i] = 32'h5A5A0000 + 32'(i);
            req_valid[i] = 1'b1; req_we[i] = 1'b0; req_addr[i] = 32'h14; req_wdata[i] = 32'd0;
            #1;
            check("ld_blocks_ready", 64'(req_ready[i]), 64'(0));
            @(negedge clk);
            ld_en[i] = 1'b0;
            mm[i][5] = 32'h5A5A0000 + 32'(i);
            push_req(1'b0, 32'h14, 32'd0);
            run(i, 50, first);
            check("accept_after_ld", 64'(first), 64'(0));
        end

        // zero wait states: store/read pair and error case
        push_req(1'b1, 32'h10, 32'h87654321);
        push_req(1'b0, 32'h10, 32'd0);
        push_req(1'b0, 32'h06, 32'd0);
        run(1, 50, first);

        // randomized batches on both instances
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 10; b++) begin
                n = $urandom_range(1, 6);
                for (int k = 0; k < n; k++) push_req(1'($urandom_range(0, 1)), rand_addr(), $urandom());
                run(i, 200, first);
                if ($urandom_range(0, 2) == 0) load(i, $urandom_range(0, 63), $urandom());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
